// File: rtl/pcm_decoder_logic_v1_pkg.sv
// PCM decoder shared types: FSM state encoding, frame field widths,
// CRC constants and a small saturating counter helper.
package pcm_decoder_logic_v1_pkg;

   localparam logic [15:0] SYNC_WORD_DEF   = 16'hEB90;
   localparam int          LOCK_THRESH_DEF = 2;
   localparam int          LOSS_THRESH_DEF = 3;

   localparam int WORD_W    = 16;
   localparam int SYNC_BITS = 16;
   localparam int DATA_BITS = 32;
   localparam int CRC_BITS  = 16;
   localparam int STATE_W   = 3;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_HUNT     = 3'd1,
      ST_RX_DATA  = 3'd2,
      ST_RX_CRC   = 3'd3,
      ST_SYNC_CHK = 3'd4
   } pdl_state_e;

   function automatic logic [2:0] sat_inc3(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

endpackage

// File: rtl/pcm_decoder_logic_v1_if.sv
// Stream-in / decoded-out bundle of the PCM decoder.
// crc_err_pdl_negreg_out exists only when PDL_CRC_EN is defined.
interface pcm_decoder_logic_v1_if;
   import pcm_decoder_logic_v1_pkg::*;

   logic              enable_pdl_in;
   logic              sdin_pdl_in;
   logic              sbit_valid_pdl_in;
   logic [WORD_W-1:0] ch1_data_pdl_negreg_out;
   logic [WORD_W-1:0] ch2_data_pdl_negreg_out;
   logic              frame_valid_pdl_negreg_out;
   logic              lock_pdl_negreg_out;
   logic              sync_err_pdl_negreg_out;
`ifdef PDL_CRC_EN
   logic              crc_err_pdl_negreg_out;
`endif
   logic [STATE_W-1:0] state_debug_pdl_out;

   modport master (
      output enable_pdl_in,
      output sdin_pdl_in,
      output sbit_valid_pdl_in,
      input  ch1_data_pdl_negreg_out,
      input  ch2_data_pdl_negreg_out,
      input  frame_valid_pdl_negreg_out,
      input  lock_pdl_negreg_out,
      input  sync_err_pdl_negreg_out,
`ifdef PDL_CRC_EN
      input  crc_err_pdl_negreg_out,
`endif
      input  state_debug_pdl_out
   );

   modport slave (
      input  enable_pdl_in,
      input  sdin_pdl_in,
      input  sbit_valid_pdl_in,
      output ch1_data_pdl_negreg_out,
      output ch2_data_pdl_negreg_out,
      output frame_valid_pdl_negreg_out,
      output lock_pdl_negreg_out,
      output sync_err_pdl_negreg_out,
`ifdef PDL_CRC_EN
      output crc_err_pdl_negreg_out,
`endif
      output state_debug_pdl_out
   );

endinterface

// File: rtl/pcm_decoder_logic_v1_crc.sv
// Serial CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first, unreflected).
// Present only in PDL_CRC_EN builds.
`ifdef PDL_CRC_EN
module crc16_ccitt_serial_v1
   import pcm_decoder_logic_v1_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        din_i,
   output logic [15:0] crc_o
);

   logic [15:0] crc_q, crc_d;
   logic        fb;

   always_comb begin
      fb    = crc_q[15] ^ din_i;
      crc_d = crc_q;
      if (clr_i) begin
         crc_d = CRC_INIT;
      end else if (en_i) begin
         crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) crc_q <= CRC_INIT;
      else       crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule
`endif

// File: rtl/pcm_decoder_logic_v1.sv
// PCM frame decoder: sync hunt, lock hysteresis, CH1/CH2 de-serialiser.
// Optional CRC-16 check over CH1|CH2 when PDL_CRC_EN is defined.
module pcm_decoder_logic_v1
   import pcm_decoder_logic_v1_pkg::*;
#(
   parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEF,
   parameter int          LOCK_THRESH = LOCK_THRESH_DEF,
   parameter int          LOSS_THRESH = LOSS_THRESH_DEF
) (
   input  logic lclk_pdl_in,
   input  logic lrst_pdl_in,
   pcm_decoder_logic_v1_if.slave bus
);

`ifdef PDL_CRC_EN
   localparam int PAY_W = DATA_BITS;
`else
   localparam int PAY_W = DATA_BITS - 1;
`endif

   pdl_state_e        state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [14:0]       sr_q, sr_d;
   logic [PAY_W-1:0]  pay_q, pay_d;
   logic [2:0]        hits_q, hits_d;
   logic [2:0]        miss_q, miss_d;
   logic              lock_q, lock_d;
   logic [WORD_W-1:0] ch1_q, ch1_d;
   logic [WORD_W-1:0] ch2_q, ch2_d;
   logic              fv_q, fv_d;
   logic              se_q, se_d;

   logic        en, stb, din;
   logic [15:0] sr_nx;
   logic [31:0] pay_nx;
   logic [2:0]  hits_inc, miss_inc;
   logic        last16, last32;

   assign en       = bus.enable_pdl_in;
   assign stb      = bus.sbit_valid_pdl_in;
   assign din      = bus.sdin_pdl_in;
   assign sr_nx    = {sr_q, din};
   assign pay_nx   = {pay_q[30:0], din};
   assign hits_inc = sat_inc3(hits_q);
   assign miss_inc = sat_inc3(miss_q);
   assign last16   = (cnt_q == 5'd15);
   assign last32   = (cnt_q == 5'd31);

`ifdef PDL_CRC_EN
   logic        ce_q, ce_d;
   logic [15:0] crc_val;
   logic        crc_clr, crc_en;

   // Seed the CRC in every state that precedes a payload.
   assign crc_clr = (state_q == ST_HUNT) ||
                    (state_q == ST_SYNC_CHK) ||
                    (state_q == ST_IDLE);
   assign crc_en  = en && stb && (state_q == ST_RX_DATA);

   crc16_ccitt_serial_v1 u_crc (
      .clk_i (lclk_pdl_in),
      .rst_i (lrst_pdl_in),
      .clr_i (crc_clr),
      .en_i  (crc_en),
      .din_i (din),
      .crc_o (crc_val)
   );
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      pay_d   = pay_q;
      hits_d  = hits_q;
      miss_d  = miss_q;
      lock_d  = lock_q;
      ch1_d   = ch1_q;
      ch2_d   = ch2_q;
      fv_d    = 1'b0;
      se_d    = 1'b0;
`ifdef PDL_CRC_EN
      ce_d    = 1'b0;
`endif
      if (!en) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         sr_d    = '0;
         hits_d  = '0;
         miss_d  = '0;
         lock_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_HUNT;
            end
            ST_HUNT: begin
               if (stb) begin
                  sr_d = sr_nx[14:0];
                  if (sr_nx == SYNC_WORD) begin
                     hits_d  = 3'd1;
                     miss_d  = '0;
                     cnt_d   = '0;
                     state_d = ST_RX_DATA;
                     if (LOCK_THRESH <= 1) lock_d = 1'b1;
                  end
               end
            end
            ST_RX_DATA: begin
               if (stb) begin
                  pay_d = pay_nx[PAY_W-1:0];
                  cnt_d = cnt_q + 5'd1;
                  if (last32) begin
                     cnt_d = '0;
`ifdef PDL_CRC_EN
                     state_d = ST_RX_CRC;
`else
                     state_d = ST_SYNC_CHK;
                     if (lock_q) begin
                        ch1_d = pay_nx[31:16];
                        ch2_d = pay_nx[15:0];
                        fv_d  = 1'b1;
                     end
`endif
                  end
               end
            end
`ifdef PDL_CRC_EN
            ST_RX_CRC: begin
               if (stb) begin
                  sr_d  = sr_nx[14:0];
                  cnt_d = cnt_q + 5'd1;
                  if (last16) begin
                     cnt_d   = '0;
                     state_d = ST_SYNC_CHK;
                     if (sr_nx != crc_val) begin
                        ce_d = 1'b1;
                     end else if (lock_q) begin
                        ch1_d = pay_q[31:16];
                        ch2_d = pay_q[15:0];
                        fv_d  = 1'b1;
                     end
                  end
               end
            end
`endif
            ST_SYNC_CHK: begin
               if (stb) begin
                  sr_d  = sr_nx[14:0];
                  cnt_d = cnt_q + 5'd1;
                  if (last16) begin
                     cnt_d = '0;
                     if (sr_nx == SYNC_WORD) begin
                        hits_d  = hits_inc;
                        miss_d  = '0;
                        state_d = ST_RX_DATA;
                        if (hits_inc >= 3'(LOCK_THRESH)) lock_d = 1'b1;
                     end else if (lock_q) begin
                        // Flywheel through isolated bad syncs.
                        se_d    = 1'b1;
                        miss_d  = miss_inc;
                        state_d = ST_RX_DATA;
                        if (miss_inc >= 3'(LOSS_THRESH)) begin
                           lock_d  = 1'b0;
                           miss_d  = '0;
                           state_d = ST_HUNT;
                        end
                     end else begin
                        hits_d  = '0;
                        state_d = ST_HUNT;
                     end
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge lclk_pdl_in) begin
      if (lrst_pdl_in) begin
         state_q <= en ? ST_HUNT : ST_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         pay_q   <= '0;
         hits_q  <= '0;
         miss_q  <= '0;
         lock_q  <= 1'b0;
         ch1_q   <= '0;
         ch2_q   <= '0;
         fv_q    <= 1'b0;
         se_q    <= 1'b0;
`ifdef PDL_CRC_EN
         ce_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         pay_q   <= pay_d;
         hits_q  <= hits_d;
         miss_q  <= miss_d;
         lock_q  <= lock_d;
         ch1_q   <= ch1_d;
         ch2_q   <= ch2_d;
         fv_q    <= fv_d;
         se_q    <= se_d;
`ifdef PDL_CRC_EN
         ce_q    <= ce_d;
`endif
      end
   end

   assign bus.ch1_data_pdl_negreg_out    = ch1_q;
   assign bus.ch2_data_pdl_negreg_out    = ch2_q;
   assign bus.frame_valid_pdl_negreg_out = fv_q;
   assign bus.lock_pdl_negreg_out        = lock_q;
   assign bus.sync_err_pdl_negreg_out    = se_q;
`ifdef PDL_CRC_EN
   assign bus.crc_err_pdl_negreg_out     = ce_q;
`endif
   assign bus.state_debug_pdl_out        = state_q;

endmodule

// File: tb/tb_pcm_decoder_logic_v1.sv
// Directed bench for pcm_decoder_logic_v1: hunt, lock, flywheel,
// loss of lock, slow strobe, enable drop and (optional) CRC errors.
module tb_pcm_decoder_logic_v1;

`ifdef PDL_CRC_EN
   localparam int FRAME_BITS = 64;
`else
   localparam int FRAME_BITS = 48;
`endif

   logic clk;
   logic rst;

   pcm_decoder_logic_v1_if bus ();

   pcm_decoder_logic_v1 dut (
      .lclk_pdl_in (clk),
      .lrst_pdl_in (rst),
      .bus         (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int gap   = 1;
   int cyc   = 0;
   int fv_cnt = 0, se_cnt = 0, ce_cnt = 0;
   int fv_last = 0, fv_prev = 0;
   int base;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (bus.frame_valid_pdl_negreg_out) begin
         fv_cnt++;
         fv_prev = fv_last;
         fv_last = cyc;
      end
      if (bus.sync_err_pdl_negreg_out) se_cnt++;
`ifdef PDL_CRC_EN
      if (bus.crc_err_pdl_negreg_out) ce_cnt++;
`endif
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] crc_ref(input logic [31:0] d);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 31; i >= 0; i--) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   task automatic tx_bit(input logic b);
      bus.sdin_pdl_in       = b;
      bus.sbit_valid_pdl_in = 1'b1;
      @(negedge clk);
      for (int i = 1; i < gap; i++) begin
         bus.sbit_valid_pdl_in = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic tx_word(input logic [15:0] w, input int nbits = 16);
      for (int i = 15; i >= 16 - nbits; i--) tx_bit(w[i]);
   endtask

   task automatic tx_pay(input logic [15:0] c1, input logic [15:0] c2,
                         input logic [15:0] flip = 16'h0);
      tx_word(c1);
      tx_word(c2);
`ifdef PDL_CRC_EN
      tx_word(crc_ref({c1, c2}) ^ flip);
`else
      if (flip != 16'h0) $display("note: flip ignored without CRC");
`endif
   endtask

   initial begin
      rst = 1'b1;
      bus.enable_pdl_in     = 1'b1;
      bus.sdin_pdl_in       = 1'b0;
      bus.sbit_valid_pdl_in = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_state", 32'(bus.state_debug_pdl_out), 32'd1);
      chk("rst_lock", 32'(bus.lock_pdl_negreg_out), 32'd0);
      chk("rst_ch1", 32'(bus.ch1_data_pdl_negreg_out), 32'd0);
      chk("rst_ch2", 32'(bus.ch2_data_pdl_negreg_out), 32'd0);
      chk("rst_fv", 32'(bus.frame_valid_pdl_negreg_out), 32'd0);
      chk("rst_se", 32'(bus.sync_err_pdl_negreg_out), 32'd0);

      // continuous strobe: acquire lock
      gap = 1;
      tx_word(16'hEB90);
      chk("sync1_lock", 32'(bus.lock_pdl_negreg_out), 32'd0);
      chk("sync1_state", 32'(bus.state_debug_pdl_out), 32'd2);
      tx_pay(16'h1234, 16'hABCD);
      tx_word(16'hEB90, 15);
      chk("sync2_pre_lock", 32'(bus.lock_pdl_negreg_out), 32'd0);
      tx_bit(1'b0);
      chk("sync2_lock", 32'(bus.lock_pdl_negreg_out), 32'd1);
      chk("no_fv_unlocked", 32'(fv_cnt), 32'd0);
      tx_pay(16'h1234, 16'hABCD);
      chk("fv_pulse", 32'(bus.frame_valid_pdl_negreg_out), 32'd1);
      chk("fv_cnt1", 32'(fv_cnt), 32'd1);
      chk("ch1_a", 32'(bus.ch1_data_pdl_negreg_out), 32'h1234);
      chk("ch2_a", 32'(bus.ch2_data_pdl_negreg_out), 32'hABCD);
      repeat (3) begin
         tx_word(16'hEB90);
         tx_pay(16'h1234, 16'hABCD);
      end
      chk("fv_cnt4", 32'(fv_cnt), 32'd4);
      chk("fv_period1", 32'(fv_last - fv_prev), 32'(FRAME_BITS));
      chk("no_se", 32'(se_cnt), 32'd0);

      // one bad sync: flywheel
      tx_word(16'hEB91);
      chk("se_pulse", 32'(bus.sync_err_pdl_negreg_out), 32'd1);
      chk("se_lock_hold", 32'(bus.lock_pdl_negreg_out), 32'd1);
      tx_pay(16'h5A5A, 16'hC3C3);
      chk("fly_fv_cnt", 32'(fv_cnt), 32'd5);
      chk("fly_ch1", 32'(bus.ch1_data_pdl_negreg_out), 32'h5A5A);
      chk("fly_ch2", 32'(bus.ch2_data_pdl_negreg_out), 32'hC3C3);
      tx_word(16'hEB90);
      chk("se_cnt1", 32'(se_cnt), 32'd1);
      tx_pay(16'h1234, 16'hABCD);

      // three bad syncs: lose lock
      tx_word(16'hEB91);
      tx_pay(16'h5555, 16'hAAAA);
      tx_word(16'hEB91);
      tx_pay(16'h5555, 16'hAAAA);
      chk("loss_pre_lock", 32'(bus.lock_pdl_negreg_out), 32'd1);
      tx_word(16'hEB91);
      chk("loss_lock", 32'(bus.lock_pdl_negreg_out), 32'd0);
      chk("loss_state", 32'(bus.state_debug_pdl_out), 32'd1);
      chk("loss_se_cnt", 32'(se_cnt), 32'd4);
      chk("loss_fv_cnt", 32'(fv_cnt), 32'd8);
      chk("loss_ch1", 32'(bus.ch1_data_pdl_negreg_out), 32'h5555);

      // strobe 1 in 4
      gap = 4;
      tx_word(16'h0000);
      base = fv_cnt;
      tx_word(16'hEB90);
      chk("slow_sync1_lock", 32'(bus.lock_pdl_negreg_out), 32'd0);
      tx_pay(16'h1234, 16'hABCD);
      chk("slow_no_fv", 32'(fv_cnt), 32'(base));
      tx_word(16'hEB90);
      chk("slow_sync2_lock", 32'(bus.lock_pdl_negreg_out), 32'd1);
      tx_pay(16'h1234, 16'hABCD);
      chk("slow_fv_cnt", 32'(fv_cnt), 32'(base + 1));
      chk("slow_ch1", 32'(bus.ch1_data_pdl_negreg_out), 32'h1234);
      chk("slow_ch2", 32'(bus.ch2_data_pdl_negreg_out), 32'hABCD);
      tx_word(16'hEB90);
      tx_pay(16'h1234, 16'hABCD);
      chk("fv_period4", 32'(fv_last - fv_prev), 32'(FRAME_BITS * 4));

      // enable drop mid-payload
      gap = 1;
      base = fv_cnt;
      tx_word(16'hEB90);
      tx_word(16'h0F0F);
      tx_word(16'hF0F0, 4);
      bus.enable_pdl_in     = 1'b0;
      bus.sbit_valid_pdl_in = 1'b0;
      @(negedge clk);
      chk("dis_state", 32'(bus.state_debug_pdl_out), 32'd0);
      chk("dis_lock", 32'(bus.lock_pdl_negreg_out), 32'd0);
      chk("dis_ch1", 32'(bus.ch1_data_pdl_negreg_out), 32'h1234);
      chk("dis_ch2", 32'(bus.ch2_data_pdl_negreg_out), 32'hABCD);
      repeat (2) @(negedge clk);
      chk("dis_no_fv", 32'(fv_cnt), 32'(base));
      bus.enable_pdl_in = 1'b1;
      @(negedge clk);
      chk("reen_state", 32'(bus.state_debug_pdl_out), 32'd1);
      tx_word(16'hEB90);
      chk("reen_sync1_lock", 32'(bus.lock_pdl_negreg_out), 32'd0);
      tx_pay(16'h0F0F, 16'hF0F0);
      tx_word(16'hEB90);
      chk("reen_sync2_lock", 32'(bus.lock_pdl_negreg_out), 32'd1);
      tx_pay(16'h0F0F, 16'hF0F0);
      chk("reen_ch1", 32'(bus.ch1_data_pdl_negreg_out), 32'h0F0F);
      chk("reen_ch2", 32'(bus.ch2_data_pdl_negreg_out), 32'hF0F0);

`ifdef PDL_CRC_EN
      // corrupted CRC word
      base = fv_cnt;
      tx_word(16'hEB90);
      tx_pay(16'h1111, 16'h2222, 16'h0004);
      chk("crc_err_pulse", 32'(bus.crc_err_pdl_negreg_out), 32'd1);
      chk("crc_no_fv", 32'(fv_cnt), 32'(base));
      chk("crc_ch1_hold", 32'(bus.ch1_data_pdl_negreg_out), 32'h0F0F);
      chk("crc_lock_hold", 32'(bus.lock_pdl_negreg_out), 32'd1);
      tx_word(16'hEB90);
      tx_pay(16'h1111, 16'h2222);
      chk("crc_ok_ch1", 32'(bus.ch1_data_pdl_negreg_out), 32'h1111);
      chk("crc_ok_ch2", 32'(bus.ch2_data_pdl_negreg_out), 32'h2222);
      chk("crc_err_cnt", 32'(ce_cnt), 32'd1);
`endif

      bus.sbit_valid_pdl_in = 1'b0;
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
